// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam int          WORD_BYTES       = 4;

    typedef enum logic {
        S_IDLE,
        S_REQ
    } fetch_state_t;

endpackage

// File: rtl/pc_target_select.sv
// Redirect selection: picks the highest-priority control-flow change (jr > jump > branch)
// and forms its target address.
module pc_target_select
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_base,
    input  logic [ADDR_W-1:0] branch_offset_sl,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic              redirect,
    output logic [ADDR_W-1:0] target,
    output logic              misaligned
);

    // Priority mux over the three redirect sources; jr drops its low bits and flags them.
    always_comb begin
        redirect   = 1'b0;
        target     = '0;
        misaligned = 1'b0;
        if (jr) begin
            redirect   = 1'b1;
            target     = {jr_addr[ADDR_W-1:2], 2'b00};
            misaligned = |jr_addr[1:0];
        end else if (jump) begin
            redirect = 1'b1;
            target   = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
        end else if (branch_taken) begin
            redirect = 1'b1;
            target   = branch_base + branch_offset_sl;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// A redirect arriving while a fetch is outstanding is parked in a pending register
// and applied when memory acknowledges, dropping the wrong-path word.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_base,
    input  logic [ADDR_W-1:0] branch_offset_sl,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misaligned
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic              pend_flag, pend_flag_next;
    logic [ADDR_W-1:0] pend_target, pend_target_next;

    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic              sel_misaligned;

    pc_target_select #(
        .ADDR_W(ADDR_W)
    ) u_target_select (
        .pc_plus4         (pc_plus4),
        .branch_taken     (branch_taken),
        .branch_base      (branch_base),
        .branch_offset_sl (branch_offset_sl),
        .jump             (jump),
        .jump_index       (jump_index),
        .jr               (jr),
        .jr_addr          (jr_addr),
        .redirect         (redirect),
        .target           (target),
        .misaligned       (sel_misaligned)
    );

    assign imem_req   = (state == S_REQ);
    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign pc_plus4   = pc + ADDR_W'(WORD_BYTES);
    // Held low while reset is asserted so a stray jr during reset does not pulse it.
    assign misaligned = sel_misaligned & reset;

    // State, PC and pending-redirect registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            pend_flag   <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pend_flag   <= pend_flag_next;
            pend_target <= pend_target_next;
        end
    end

    // Fetch sequencing: next PC selection, redirect parking and instr_valid generation.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        pend_flag_next   = pend_flag;
        pend_target_next = pend_target;
        instr_valid      = 1'b0;
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_next = target;
                end
                if (!stall) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    instr_valid    = !redirect && !pend_flag;
                    pend_flag_next = 1'b0;
                    if (redirect) begin
                        pc_next = target;
                    end else if (pend_flag) begin
                        pc_next = pend_target;
                    end else begin
                        pc_next = pc + ADDR_W'(WORD_BYTES);
                    end
                    if (stall) begin
                        state_next = S_IDLE;
                    end
                end else if (redirect) begin
                    pend_flag_next   = 1'b1;
                    pend_target_next = target;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_base;
    logic [31:0] branch_offset_sl;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        misaligned;

    int checks;
    int failures;

    pc_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_base      (branch_base),
        .branch_offset_sl (branch_offset_sl),
        .jump             (jump),
        .jump_index       (jump_index),
        .jr               (jr),
        .jr_addr          (jr_addr),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .instr_valid      (instr_valid),
        .pc_out           (pc_out),
        .pc_plus4         (pc_plus4),
        .misaligned       (misaligned)
    );

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall            = 1'b0;
        branch_taken     = 1'b0;
        branch_base      = '0;
        branch_offset_sl = '0;
        jump             = 1'b0;
        jump_index       = '0;
        jr               = 1'b0;
        jr_addr          = '0;
        imem_ack         = 1'b0;
    endtask

    // Reset and release; returns at a falling edge with the first fetch at RST_PC outstanding.
    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset   = 1'b0;
        jr      = 1'b1;
        jr_addr = 32'h0000_0003;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_req got=%b exp=0", imem_req);
        end
        checks++;
        if (pc_out !== RST_PC) begin
            failures++;
            $display("[TB] FAIL reset_pc got=%h exp=%h", pc_out, RST_PC);
        end
        checks++;
        if (pc_plus4 !== 32'h0040_0004) begin
            failures++;
            $display("[TB] FAIL reset_pc_plus4 got=%h exp=00400004", pc_plus4);
        end
        checks++;
        if (instr_valid !== 1'b0 || misaligned !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_pulses got valid=%b mis=%b exp 0/0", instr_valid, misaligned);
        end
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_idle_req got=%b exp=0", imem_req);
        end
        @(negedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++;
            $display("[TB] FAIL first_issue got req=%b addr=%h exp 1/%h", imem_req, imem_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            exp_addr = RST_PC + 32'(4 * i);
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_addr || instr_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL seq_fetch%0d got req=%b addr=%h valid=%b exp 1/%h/1",
                         i, imem_req, imem_addr, instr_valid, exp_addr);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_ack_delay();
        int pulses;
        do_reset();
        imem_ack = 1'b1;
        @(negedge clk);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 3);
            #1;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin
                failures++;
                $display("[TB] FAIL delay_hold%0d got req=%b addr=%h exp 1/00400004", i, imem_req, imem_addr);
            end
            if (instr_valid === 1'b1) pulses++;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        #1;
        checks++;
        if (pulses != 1 || imem_addr !== 32'h0040_0008) begin
            failures++;
            $display("[TB] FAIL delay_result got pulses=%0d addr=%h exp 1/00400008", pulses, imem_addr);
        end
        clear_inputs();
    endtask

    task automatic test_branch_ack();
        do_reset();
        imem_ack         = 1'b1;
        @(negedge clk);
        imem_ack         = 1'b1;
        branch_taken     = 1'b1;
        branch_base      = 32'h0040_0010;
        branch_offset_sl = 32'hFFFF_FFF0;
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL branch_drop got valid=%b exp=0", instr_valid);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000) begin
            failures++;
            $display("[TB] FAIL branch_target got req=%b addr=%h exp 1/00400000", imem_req, imem_addr);
        end
    endtask

    task automatic test_jump_pending();
        do_reset();
        jump       = 1'b1;
        jump_index = 26'h000_0100;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== RST_PC) begin
            failures++;
            $display("[TB] FAIL jump_wait got valid=%b addr=%h exp 0/%h", instr_valid, imem_addr, RST_PC);
        end
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        imem_ack = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== RST_PC) begin
            failures++;
            $display("[TB] FAIL jump_pend_drop got valid=%b addr=%h exp 0/%h", instr_valid, imem_addr, RST_PC);
        end
        @(negedge clk);
        #1;
        checks++;
        if (imem_addr !== 32'h0000_0400 || instr_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL jump_pend_target got addr=%h valid=%b exp 00000400/1", imem_addr, instr_valid);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_jr_priority();
        do_reset();
        imem_ack         = 1'b1;
        jr               = 1'b1;
        jr_addr          = 32'h0040_0082;
        branch_taken     = 1'b1;
        branch_base      = 32'h0000_1000;
        branch_offset_sl = 32'h0000_0010;
        jump             = 1'b1;
        jump_index       = 26'h3FF_FFFF;
        #1;
        checks++;
        if (misaligned !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jr_misaligned got mis=%b valid=%b exp 1/0", misaligned, instr_valid);
        end
        @(negedge clk);
        clear_inputs();
        jump       = 1'b1;
        jump_index = 26'h000_0040;
        branch_taken     = 1'b1;
        branch_base      = 32'h0000_2000;
        branch_offset_sl = 32'h0000_0004;
        imem_ack   = 1'b1;
        #1;
        checks++;
        if (imem_addr !== 32'h0040_0080 || misaligned !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jr_target got addr=%h mis=%b exp 00400080/0", imem_addr, misaligned);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (imem_addr !== 32'h0000_0100) begin
            failures++;
            $display("[TB] FAIL jump_over_branch got addr=%h exp 00000100", imem_addr);
        end
    endtask

    task automatic test_stall_and_reset();
        do_reset();
        stall    = 1'b1;
        imem_ack = 1'b1;
        #1;
        checks++;
        if (instr_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_ack_valid got=%b exp=1", instr_valid);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'(i & 1);
            #1;
            checks++;
            if (imem_req !== 1'b0 || pc_out !== 32'h0040_0004 || instr_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d got req=%b pc=%h valid=%b exp 0/00400004/0",
                         i, imem_req, pc_out, instr_valid);
            end
            @(negedge clk);
        end
        clear_inputs();
        @(negedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0004) begin
            failures++;
            $display("[TB] FAIL stall_resume got req=%b addr=%h exp 1/00400004", imem_req, imem_addr);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc_out !== RST_PC) begin
            failures++;
            $display("[TB] FAIL reset_mid_fetch got req=%b pc=%h exp 0/%h", imem_req, pc_out, RST_PC);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        imem_ack = 1'b1;
        jr       = 1'b1;
        jr_addr  = 32'hFFFF_FFFC;
        @(negedge clk);
        jr = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0000_0000 || instr_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wrap_top got addr=%h p4=%h valid=%b exp FFFFFFFC/00000000/1",
                     imem_addr, pc_plus4, instr_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (imem_addr !== 32'h0000_0000) begin
            failures++;
            $display("[TB] FAIL wrap_zero got addr=%h exp 00000000", imem_addr);
        end
        clear_inputs();
    endtask

    // Randomized run against a fetch-transaction model: one outstanding fetch,
    // plus at most one parked redirect where the newest request replaces the older.
    task automatic test_random();
        logic [31:0] m_pc;
        bit          m_busy;
        logic [31:0] parked[$];
        bit          any_redir;
        logic [31:0] tgt;
        bit          exp_valid;
        bit          exp_mis;
        do_reset();
        m_pc   = RST_PC;
        m_busy = 1'b1;
        parked = {};
        for (int n = 0; n < 400; n++) begin
            stall            = ($urandom_range(0, 3) == 0);
            imem_ack         = ($urandom_range(0, 1) == 1);
            branch_taken     = ($urandom_range(0, 6) == 0);
            jump             = ($urandom_range(0, 7) == 0);
            jr               = ($urandom_range(0, 8) == 0);
            branch_base      = $urandom;
            branch_offset_sl = $urandom & 32'hFFFF_FFFC;
            jump_index       = 26'($urandom);
            jr_addr          = $urandom;
            any_redir = jr || jump || branch_taken;
            if (jr)
                tgt = jr_addr - (jr_addr % 4);
            else if (jump)
                tgt = ((m_pc + 4) & 32'hF000_0000) + 32'(jump_index) * 4;
            else
                tgt = branch_base + branch_offset_sl;
            exp_mis   = jr && (jr_addr % 4 != 0);
            exp_valid = m_busy && imem_ack && !any_redir && parked.size() == 0;
            #1;
            checks++;
            if (imem_req !== m_busy || imem_addr !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
                failures++;
                $display("[TB] FAIL rand_fetch n=%0d got req=%b addr=%h p4=%h exp %b/%h/%h",
                         n, imem_req, imem_addr, pc_plus4, m_busy, m_pc, m_pc + 32'd4);
            end
            checks++;
            if (instr_valid !== exp_valid || misaligned !== exp_mis) begin
                failures++;
                $display("[TB] FAIL rand_pulse n=%0d got valid=%b mis=%b exp %b/%b",
                         n, instr_valid, misaligned, exp_valid, exp_mis);
            end
            if (!m_busy) begin
                if (any_redir) m_pc = tgt;
                m_busy = !stall;
            end else if (imem_ack) begin
                if (any_redir)               m_pc = tgt;
                else if (parked.size() != 0) m_pc = parked[0];
                else                         m_pc = m_pc + 32'd4;
                parked = {};
                m_busy = !stall;
            end else if (any_redir) begin
                parked = {tgt};
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_ack_delay();
        test_branch_ack();
        test_jump_pending();
        test_jr_priority();
        test_stall_and_reset();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
